code_lock_ctrl: RTL

CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

---
 rtl/code_lock_pkg.sv | 7 +
 rtl/code_lock_ctrl_if.sv | 15 +
 rtl/lock_timer.sv | 19 +
 rtl/code_lock_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared types and widths for the keypad code lock.
package code_lock_pkg;
  localparam int DIGIT_W = 4;
  localparam int TIMER_W = 24;
  localparam int TRIES_W = 3;
  typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;
endpackage

// File: rtl/code_lock_ctrl_if.sv
// code_lock_ctrl_if: keypad inputs and lock status outputs of the code lock.
interface code_lock_ctrl_if;
  logic                                digit_valid;
  logic [code_lock_pkg::DIGIT_W-1:0]   digit;
  logic                                relock;
  logic                                unlock;
  logic                                alarm;
  logic [code_lock_pkg::TRIES_W-1:0]   tries;
  logic                                led_open_n;
  logic                                led_alarm_n;
  modport master (output digit_valid, digit, relock,
                  input  unlock, alarm, tries, led_open_n, led_alarm_n);
  modport slave  (input  digit_valid, digit, relock,
                  output unlock, alarm, tries, led_open_n, led_alarm_n);
endinterface

// File: rtl/lock_timer.sv
// lock_timer: saturating cycle counter with clear and terminal-count compare.
module lock_timer
  import code_lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [TIMER_W-1:0] limit_i,
  output logic               tc_o
);
  logic [TIMER_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  // tc marks the last cycle of a limit_i-cycle window started at count 0
  assign tc_o = en_i && cnt_q == limit_i - 1'b1;
endmodule

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: keypad code lock with entry timeout, unlock hold and lockout.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int                          CODE_LEN    = 4,
  parameter logic [DIGIT_W*CODE_LEN-1:0] CODE        = 16'h7391,
  parameter int                          MAX_TRIES   = 3,
  parameter logic [TIMER_W-1:0]          TIMEOUT_CYC = 24'd12_000_000,
  // large defaults keep the value a 24-bit literal of them would hold
  parameter logic [TIMER_W-1:0]          OPEN_CYC    = TIMER_W'(60_000_000),
  parameter logic [TIMER_W-1:0]          LOCK_CYC    = TIMER_W'(120_000_000)
)(
  input  logic clk,
  input  logic rst,
  code_lock_ctrl_if.slave bus
);
  localparam logic [TRIES_W-1:0] MAXT = TRIES_W'(MAX_TRIES);
  state_t               st_q;
  logic [2:0]           idx_q;
  logic                 mis_q, unlock_q, alarm_q;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic                 mis_d, last, tc, clr, dv;
  logic [TIMER_W-1:0]   limit;
  logic [31:0]          code_ext;
  logic [DIGIT_W-1:0]   ref_dig;
  assign dv       = bus.digit_valid;
  assign code_ext = 32'(CODE);
  // idx is 0 in IDLE, so the same lookup serves the first digit
  assign ref_dig  = code_ext[{idx_q, 2'b00} +: DIGIT_W];
  assign mis_d    = mis_q | (bus.digit != ref_dig);
  assign last     = idx_q == 3'(CODE_LEN - 1);
  assign tries_d  = tries_q + 1'b1;
  assign limit    = st_q == OPEN ? OPEN_CYC : st_q == LOCKOUT ? LOCK_CYC : TIMEOUT_CYC;
  assign clr      = (st_q == IDLE || st_q == ENTRY) ? dv || tc :
                    st_q == OPEN ? tc || bus.relock : tc;
  lock_timer u_tmr (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (clr),
    .en_i    (st_q != IDLE),
    .limit_i (limit),
    .tc_o    (tc)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_q     <= IDLE;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      tries_q  <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      case (st_q)
        IDLE, ENTRY:
          if (tc || (dv && last)) begin
            idx_q <= '0;
            mis_q <= 1'b0;
            if (!tc && !mis_d) begin
              st_q     <= OPEN;
              tries_q  <= '0;
              unlock_q <= 1'b1;
            end else begin
              tries_q <= tries_d;
              st_q    <= tries_d == MAXT ? LOCKOUT : IDLE;
              alarm_q <= tries_d == MAXT;
            end
          end else if (dv) begin
            idx_q <= idx_q + 1'b1;
            mis_q <= mis_d;
            st_q  <= ENTRY;
          end
        OPEN:
          if (tc || bus.relock) begin
            st_q     <= IDLE;
            unlock_q <= 1'b0;
          end
        LOCKOUT:
          if (tc) begin
            st_q    <= IDLE;
            alarm_q <= 1'b0;
            tries_q <= '0;
          end
        default: st_q <= IDLE;
      endcase
    end
  assign bus.unlock      = unlock_q;
  assign bus.alarm       = alarm_q;
  assign bus.tries       = tries_q;
  assign bus.led_open_n  = ~unlock_q;
  assign bus.led_alarm_n = ~alarm_q;
endmodule
